store_seq_ctrl: RTL and testbench
=================================

Name: store_seq_ctrl

Overview:
- Sequences RISC-V store operations (sb/sh/sw) from the execute stage onto the data-memory write port.
- Captures one store request per handshake and forms byte-lane data and write strobes from the address offset.
- Drives a request/acknowledge memory write and reports completion or error back to the core, so the core stalls while a store is in flight.
- Optionally splits stores that cross a 32-bit word boundary into two memory beats.

Parameters:
- ADDR_W, 32, byte-address width of st_addr and mem_addr.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- st_valid  input  1  core presents a store request.
- st_ready  output  1  controller can accept a request (high only in IDLE).
- st_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- st_addr  input  ADDR_W  byte address.
- st_data  input  32  rs2 value; only the low 8/16/32 bits are used, according to st_size.
- st_done  output  1  one-cycle pulse: store finished, or rejected.
- st_err  output  1  qualified by st_done; 1 = misaligned or illegal-size store, no memory write performed.
- mem_req  output  1  write request, held until acknowledged.
- mem_addr  output  ADDR_W  word-aligned write address; bits [1:0] always 0.
- mem_wdata  output  32  lane-positioned write data.
- mem_wstrb  output  4  byte enables; bit i enables bits [8i+7:8i].
- mem_ack  input  1  memory accepted the current beat.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low. While rst_n=0:
  - state = IDLE
  - st_ready = 1
  - st_done, st_err, mem_req, busy = 0
  - mem_addr, mem_wdata, mem_wstrb = 0
- All outputs are registered except st_ready, which is decoded from state.
- Accept: a store is accepted when st_valid && st_ready at a rising edge. The controller then latches size, address and data.
  - Let off = st_addr[1:0].
  - Let D = the size-masked data zero-extended to 64 bits, shifted left by 8*off.
  - Let M = the mask 0001/0011/1111 (byte/half/word), zero-extended to 8 bits, shifted left by off.
  - Cross = (M[7:4] != 0).
- States: IDLE, WR_LO, WR_HI, RESP.
- IDLE, on accept:
  - st_size = 11 -> RESP with st_err = 1.
  - Cross with the macro absent -> RESP with st_err = 1.
  - Otherwise -> WR_LO: mem_req = 1, mem_addr = {addr[ADDR_W-1:2], 00}, mem_wdata = D[31:0], mem_wstrb = M[3:0].
- WR_LO: hold mem_req and all mem_* outputs stable until mem_ack.
  - On mem_ack, if Cross -> WR_HI: mem_addr += 4, mem_wdata = D[63:32], mem_wstrb = M[7:4], mem_req stays 1.
  - On mem_ack, if not Cross -> RESP with mem_req = 0 and st_err = 0.
- WR_HI: hold outputs until mem_ack, then -> RESP with mem_req = 0 and st_err = 0.
- RESP: st_done = 1 for exactly one cycle, then -> IDLE. st_err is valid while st_done is high and is cleared on the next cycle.
- Latency:
  - Accept at edge 0; mem_req is high after edge 0.
  - If mem_ack is high at edge N, st_done is high after edge N+1 (aligned single beat).
  - Errors: st_done is high after edge 1.
- No new request is accepted until the cycle after st_done, because st_ready is low in RESP.
- mem_ack is ignored in IDLE and RESP. mem_ack is permitted in the same cycle mem_req first rises.
- mem_addr wrap: addr + 4 wraps modulo 2^ADDR_W, with no error.
- Reset mid-operation: mem_req drops immediately and asynchronously; the pending store is abandoned, with no st_done.

Optional Feature:
- Macro: STORE_SEQ_MISALIGN_SPLIT_EN.
- Defined: boundary-crossing half/word stores run as two beats (WR_LO then WR_HI) with st_err = 0. Non-crossing misaligned stores, e.g. a half at off=1, complete in one beat.
- Undefined: WR_HI is not built. Any Cross store is rejected with st_done and st_err = 1 and no mem_req. Non-crossing misaligned stores still complete in one beat.

Test Plan:
- sb, addr 0x1003, data 0xAABBCC5A, ack 1 cycle after req -> one beat: mem_addr 0x1000, mem_wstrb 1000, mem_wdata[31:24] = 0x5A; st_done 2 cycles after accept, st_err = 0.
- sh, addr 0x2002, data 0x0000BEEF, ack delayed 3 cycles -> mem_req and mem_* held stable for 3 cycles; mem_wstrb 1100, mem_wdata 0xBEEF0000.
- sw, addr 0x3001, data 0x11223344, macro defined -> beat 1: addr 0x3000, wstrb 1110, wdata 0x22334400; beat 2: addr 0x3004, wstrb 0001, wdata 0x00000011; st_err = 0.
- Same store with the macro undefined -> no mem_req; st_done and st_err = 1 one cycle after accept.
- st_size = 11 -> st_err = 1; back-to-back st_valid is refused (st_ready = 0) until IDLE.
- rst_n pulled low in WR_LO -> mem_req = 0 immediately, no st_done; after release the next sw at 0x0 completes normally.

Source files
------------

// File: rtl/store_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : store_seq_ctrl
//  Purpose  : Sequences RISC-V sb/sh/sw stores onto a req/ack memory write
//             port with lane-positioned data and byte strobes.
//             Optional macro STORE_SEQ_MISALIGN_SPLIT_EN splits word-crossing
//             stores into two beats; without it such stores are rejected.
//  Revision : 1.0 - initial release
// ============================================================================
module store_seq_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t r_state;

    logic [31:0]       w_data_sz;
    logic [3:0]        w_mask_sz;
    logic [7:0]        w_mask8;
    logic              w_cross;
    logic              w_illegal;
    logic [31:0]       w_lo_data;
    logic [ADDR_W-1:0] w_word_addr;

    always_comb begin
        w_data_sz = 32'd0;
        w_mask_sz = 4'b0000;
        case (st_size)
            2'b00: begin
                w_data_sz = {24'd0, st_data[7:0]};
                w_mask_sz = 4'b0001;
            end
            2'b01: begin
                w_data_sz = {16'd0, st_data[15:0]};
                w_mask_sz = 4'b0011;
            end
            2'b10: begin
                w_data_sz = st_data;
                w_mask_sz = 4'b1111;
            end
            default: begin
                w_data_sz = 32'd0;
                w_mask_sz = 4'b0000;
            end
        endcase
    end

    assign w_mask8     = {4'b0000, w_mask_sz} << st_addr[1:0];
    assign w_cross     = |w_mask8[7:4];
    assign w_illegal   = (st_size == 2'b11);
    assign w_word_addr = {st_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
    logic [63:0] w_data64;
    logic        r_cross;
    logic [31:0] r_hi_data;
    logic [3:0]  r_hi_strb;

    assign w_data64  = {32'd0, w_data_sz} << {st_addr[1:0], 3'b000};
    assign w_lo_data = w_data64[31:0];
`else
    assign w_lo_data = w_data_sz << {st_addr[1:0], 3'b000};
`endif

    assign st_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'b0000;
            busy      <= 1'b0;
`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
            r_cross   <= 1'b0;
            r_hi_data <= 32'd0;
            r_hi_strb <= 4'b0000;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    st_done <= 1'b0;
                    st_err  <= 1'b0;
                    if (st_valid) begin
                        busy <= 1'b1;
`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
                        if (w_illegal) begin
`else
                        if (w_illegal || w_cross) begin
`endif
                            r_state <= RESP;
                            st_err  <= 1'b1;
                        end else begin
                            r_state   <= WR_LO;
                            mem_req   <= 1'b1;
                            mem_addr  <= w_word_addr;
                            mem_wdata <= w_lo_data;
                            mem_wstrb <= w_mask8[3:0];
`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
                            r_cross   <= w_cross;
                            r_hi_data <= w_data64[63:32];
                            r_hi_strb <= w_mask8[7:4];
`endif
                        end
                    end
                end

                WR_LO: begin
                    if (mem_ack) begin
`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
                        if (r_cross) begin
                            r_state   <= WR_HI;
                            mem_addr  <= mem_addr + ADDR_W'(32'd4);
                            mem_wdata <= r_hi_data;
                            mem_wstrb <= r_hi_strb;
                        end else begin
                            r_state <= RESP;
                            mem_req <= 1'b0;
                            st_err  <= 1'b0;
                        end
`else
                        r_state <= RESP;
                        mem_req <= 1'b0;
                        st_err  <= 1'b0;
`endif
                    end
                end

`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
                WR_HI: begin
                    if (mem_ack) begin
                        r_state <= RESP;
                        mem_req <= 1'b0;
                        st_err  <= 1'b0;
                    end
                end
`endif

                // First RESP cycle raises st_done; the second retires it, so
                // st_ready stays low for the whole st_done pulse.
                RESP: begin
                    if (!st_done) begin
                        st_done <= 1'b1;
                    end else begin
                        st_done <= 1'b0;
                        st_err  <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_seq_ctrl
//  Purpose  : Directed scoreboard bench for store_seq_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          dly;
        bit          err;
        int          nb;
        logic [31:0] a0, w0, a1, w1;
        logic [3:0]  s0, s1;
    } vec_t;

    beat_t exp_beats[$];
    bit    exp_done[$];

    store_seq_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_size   (st_size),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares the presented beat every cycle it is held, pops on ack.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                tests++;
                if (exp_beats.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_mem_req: got addr 0x%08h expected no request", mem_addr);
                end else begin
                    if (mem_addr !== exp_beats[0].addr || mem_wdata !== exp_beats[0].wdata ||
                        mem_wstrb !== exp_beats[0].wstrb) begin
                        fails++;
                        $display("FAIL beat: got addr 0x%08h data 0x%08h strb %b expected addr 0x%08h data 0x%08h strb %b",
                                 mem_addr, mem_wdata, mem_wstrb,
                                 exp_beats[0].addr, exp_beats[0].wdata, exp_beats[0].wstrb);
                    end
                    if (mem_ack) void'(exp_beats.pop_front());
                end
            end
            if (st_done) begin
                tests++;
                if (exp_done.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got st_done=1 expected 0");
                end else begin
                    bit e;
                    e = exp_done.pop_front();
                    if (st_err !== e) begin
                        fails++;
                        $display("FAIL st_err: got %0b expected %0b", st_err, e);
                    end
                    if (exp_beats.size() != 0) begin
                        fails++;
                        $display("FAIL beats_left_at_done: got %0d expected 0", exp_beats.size());
                    end
                end
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                                input int dly, input bit err, input int nb,
                                input logic [31:0] a0, input logic [31:0] w0, input logic [3:0] s0,
                                input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] s1);
        vec_t v;
        v.size = size; v.addr = addr; v.data = data; v.dly = dly; v.err = err; v.nb = nb;
        v.a0 = a0; v.w0 = w0; v.s0 = s0; v.a1 = a1; v.w1 = w1; v.s1 = s1;
        return v;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!st_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!st_ready) check("ready_timeout", 32'(st_ready), 32'd1);
    endtask

    // Issue one store, answer each beat after v.dly idle cycles, check latency.
    task automatic run_vec(input vec_t v);
        int    k, bi, bstart, lat, exp_lat;
        beat_t b;
        wait_ready();
        if (v.err) begin
            exp_done.push_back(1'b1);
        end else begin
            b.addr = v.a0; b.wdata = v.w0; b.wstrb = v.s0;
            exp_beats.push_back(b);
            if (v.nb == 2) begin
                b.addr = v.a1; b.wdata = v.w1; b.wstrb = v.s1;
                exp_beats.push_back(b);
            end
            exp_done.push_back(1'b0);
        end
        st_valid = 1'b1; st_size = v.size; st_addr = v.addr; st_data = v.data;
        @(posedge clk); #1;
        st_valid = 1'b0;
        bi = 0; bstart = 0; lat = -1;
        for (k = 0; k < 60; k++) begin
            mem_ack = (!v.err && bi < v.nb && (k - bstart) == v.dly);
            @(negedge clk);
            if (st_done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            if (mem_ack) begin
                bi++;
                bstart = k + 1;
            end
            #1;
        end
        mem_ack = 1'b0;
        exp_lat = v.err ? 1 : v.nb * (v.dly + 1) + 1;
        check("done_latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[$];
        rst_n = 1'b0; st_valid = 1'b0; st_size = 2'b00; st_addr = 32'd0; st_data = 32'd0; mem_ack = 1'b0;

        #2;
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_outputs", {25'd0, st_done, st_err, mem_req, busy, mem_wstrb[2:0]}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mk(2'b00, 32'h0000_1003, 32'hAABB_CC5A, 0, 0, 1,
                          32'h0000_1000, 32'h5A00_0000, 4'b1000, 32'd0, 32'd0, 4'd0));
        vecs.push_back(mk(2'b01, 32'h0000_2002, 32'h0000_BEEF, 3, 0, 1,
                          32'h0000_2000, 32'hBEEF_0000, 4'b1100, 32'd0, 32'd0, 4'd0));
        vecs.push_back(mk(2'b01, 32'h0000_2001, 32'h1234_ABCD, 0, 0, 1,
                          32'h0000_2000, 32'h00AB_CD00, 4'b0110, 32'd0, 32'd0, 4'd0));
        vecs.push_back(mk(2'b10, 32'h0000_4000, 32'hCAFE_F00D, 2, 0, 1,
                          32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 32'd0, 32'd0, 4'd0));
        vecs.push_back(mk(2'b00, 32'h0000_5001, 32'h1234_56F0, 1, 0, 1,
                          32'h0000_5000, 32'h0000_F000, 4'b0010, 32'd0, 32'd0, 4'd0));
`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
        vecs.push_back(mk(2'b10, 32'h0000_3001, 32'h1122_3344, 1, 0, 2,
                          32'h0000_3000, 32'h2233_4400, 4'b1110, 32'h0000_3004, 32'h0000_0011, 4'b0001));
        vecs.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'h0000_A55A, 0, 0, 2,
                          32'hFFFF_FFFC, 32'h5A00_0000, 4'b1000, 32'h0000_0000, 32'h0000_00A5, 4'b0001));
`else
        vecs.push_back(mk(2'b10, 32'h0000_3001, 32'h1122_3344, 1, 1, 0,
                          32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0));
        vecs.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'h0000_A55A, 0, 1, 0,
                          32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0));
`endif
        foreach (vecs[i]) run_vec(vecs[i]);

        // Illegal size with st_valid held high: second request must be refused.
        wait_ready();
        exp_done.push_back(1'b1);
        st_valid = 1'b1; st_size = 2'b11; st_addr = 32'h0000_0010; st_data = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check("illegal_ready_e0", 32'(st_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("illegal_ready_e1", 32'(st_ready), 32'd0);
        check("illegal_done_e1", 32'(st_done), 32'd1);
        @(posedge clk); #1;
        st_valid = 1'b0; st_size = 2'b00;
        @(negedge clk);
        check("illegal_ready_e2", 32'(st_ready), 32'd1);
        check("illegal_busy_e2", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("illegal_no_reaccept", 32'(busy), 32'd0);

        // Reset while WR_LO waits for an ack that never comes.
        wait_ready();
        begin
            beat_t b;
            b.addr = 32'h0000_0000; b.wdata = 32'h0123_4567; b.wstrb = 4'b1111;
            exp_beats.push_back(b);
            exp_done.push_back(1'b0);
        end
        st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_0000; st_data = 32'h0123_4567;
        @(posedge clk); #1;
        st_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_mem_req", 32'(mem_req), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        exp_beats.delete();
        exp_done.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(st_done), 32'd0);
        end
        @(posedge clk); #1;
        run_vec(mk(2'b10, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 1,
                   32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 32'd0, 32'd0, 4'd0));

        repeat (3) @(posedge clk);
        check("beats_left", 32'(exp_beats.size()), 32'd0);
        check("dones_left", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
